// File: rtl/weight_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_load_pkg
//  Description : Shared types and constants for the weight load sequencer:
//                FSM state encoding, lane count and the lane indices of the
//                packed stream word {a_0,b_0,c_0,d_0,a_1,b_1,c_1,d_1}.
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_SET   = 2'd3
    } state_e;

    localparam int LANES = 8;

    // Lane index within the packed word; lane 7 occupies the MSBs.
    localparam int LANE_A0 = 7;
    localparam int LANE_B0 = 6;
    localparam int LANE_C0 = 5;
    localparam int LANE_D0 = 4;
    localparam int LANE_A1 = 3;
    localparam int LANE_B1 = 2;
    localparam int LANE_C1 = 1;
    localparam int LANE_D1 = 0;

endpackage
`default_nettype wire

// File: rtl/weight_load_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : weight_load_sequencer_if
//  Description : Valid/ready stream carrying one 8-lane weight-exponent word
//                from the weight buffer read port to the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface weight_load_sequencer_if #(
    parameter int WEIGHT_WIDTH = 8
);
    import weight_load_pkg::*;

    logic                          s_valid_i;
    logic                          s_ready_o;
    logic [LANES*WEIGHT_WIDTH-1:0] s_data_i;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/weight_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : weight_load_sequencer
//  Description : Head of the separate-sum-unit weight daisy chain. Shifts
//                exactly CHAIN_DEPTH stream words into the chain with
//                prepare_weight_o, then pulses set_weight_o on request so all
//                units latch their preloaded exponents.
//                Optional build macro WEIGHT_LOAD_ABORT_EN adds abort_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_load_sequencer
    import weight_load_pkg::*;
#(
    parameter int CHAIN_DEPTH  = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef WEIGHT_LOAD_ABORT_EN
    input  logic                    abort_i,
`endif
    input  logic                    start_i,
    input  logic                    set_req_i,
    weight_load_sequencer_if.slave  s_if,
    output logic                    prepare_weight_o,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_a_0,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_b_0,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_c_0,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_d_0,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_a_1,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_b_1,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_c_1,
    output logic [WEIGHT_WIDTH-1:0] o_load_weight_data_d_1,
    output logic                    set_weight_o,
    output logic                    busy_o,
    output logic                    loaded_o
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(CHAIN_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(CHAIN_DEPTH - 1);

    state_e                                state_q, state_d;
    logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
    logic                                  prepare_q;
    logic [LANES-1:0][WEIGHT_WIDTH-1:0]    data_q;
    logic                                  ready;
    logic                                  handshake;
    logic                                  abort_req;

`ifdef WEIGHT_LOAD_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    // Ready depends only on state and count, never on s_valid_i.
    assign ready          = (state_q == ST_LOAD) && (cnt_q < DEPTH_CNT);
    assign s_if.s_ready_o = ready;
    assign handshake      = s_if.s_valid_i & ready;

    // State and load-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort beats set_req, and in IDLE start is the only exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_READY;
                    end
                end
                if (abort_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (set_req_i) begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Chain head registers: capture on handshake, hold otherwise so the
    // downstream units see stable data while prepare_weight is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prepare_q <= 1'b0;
            data_q    <= '0;
        end else begin
            prepare_q <= handshake;
            if (handshake) begin
                data_q <= s_if.s_data_i;
            end
        end
    end

    assign prepare_weight_o       = prepare_q;
    assign o_load_weight_data_a_0 = data_q[LANE_A0];
    assign o_load_weight_data_b_0 = data_q[LANE_B0];
    assign o_load_weight_data_c_0 = data_q[LANE_C0];
    assign o_load_weight_data_d_0 = data_q[LANE_D0];
    assign o_load_weight_data_a_1 = data_q[LANE_A1];
    assign o_load_weight_data_b_1 = data_q[LANE_B1];
    assign o_load_weight_data_c_1 = data_q[LANE_C1];
    assign o_load_weight_data_d_1 = data_q[LANE_D1];

    assign set_weight_o = (state_q == ST_SET);
    assign busy_o       = (state_q != ST_IDLE);
    assign loaded_o     = (state_q == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_weight_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_load_sequencer
//  Description : Directed self-checking bench for weight_load_sequencer with
//                CHAIN_DEPTH = 4. Abort scenario compiled in when
//                WEIGHT_LOAD_ABORT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_load_sequencer;

    localparam int D  = 4;
    localparam int WW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic set_req_i = 1'b0;
`ifdef WEIGHT_LOAD_ABORT_EN
    logic abort_i = 1'b0;
`endif
    logic          prep;
    logic          set_w;
    logic          busy;
    logic          loaded;
    logic [WW-1:0] a0, b0, c0, d0, a1, b1, c1, d1;

    int vectors = 0;
    int miscompares = 0;

    weight_load_sequencer_if #(.WEIGHT_WIDTH(WW)) s_if ();

    weight_load_sequencer #(
        .CHAIN_DEPTH (D),
        .WEIGHT_WIDTH(WW),
        .CNT_WIDTH   (3)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
`ifdef WEIGHT_LOAD_ABORT_EN
        .abort_i               (abort_i),
`endif
        .start_i               (start_i),
        .set_req_i             (set_req_i),
        .s_if                  (s_if),
        .prepare_weight_o      (prep),
        .o_load_weight_data_a_0(a0),
        .o_load_weight_data_b_0(b0),
        .o_load_weight_data_c_0(c0),
        .o_load_weight_data_d_0(d0),
        .o_load_weight_data_a_1(a1),
        .o_load_weight_data_b_1(b1),
        .o_load_weight_data_c_1(c1),
        .o_load_weight_data_d_1(d1),
        .set_weight_o          (set_w),
        .busy_o                (busy),
        .loaded_o              (loaded)
    );

    always #5 clk = ~clk;

    // Status vector {busy, loaded, s_ready, prepare_weight, set_weight}.
    logic [4:0] st;
    assign st = {busy, loaded, s_if.s_ready_o, prep, set_w};

    logic [8*WW-1:0] lanes;
    assign lanes = {a0, b0, c0, d0, a1, b1, c1, d1};

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_status: got %b want 00000", st);
        end
        vectors++;
        if (lanes !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", lanes);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        vectors++;
        if (st !== 5'b10100) begin
            miscompares++;
            $display("FAIL b2b_start: got %b want 10100", st);
        end
        for (int w = 1; w <= D; w++) begin
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = {8{8'(w)}};
            tick();
            vectors++;
            if (st !== ((w == D) ? 5'b11010 : 5'b10110) || a0 !== 8'(w)) begin
                miscompares++;
                $display("FAIL b2b_word%0d: status %b a_0 %h, want %b a_0 %h",
                         w, st, a0, (w == D) ? 5'b11010 : 5'b10110, 8'(w));
            end
        end
        s_if.s_valid_i = 1'b0;
        tick();
        vectors++;
        if (st !== 5'b11000 || lanes !== {8{8'h04}}) begin
            miscompares++;
            $display("FAIL b2b_after: status %b data %h, want 11000 data 0404..", st, lanes);
        end
    endtask

    task automatic test_set();
        // start_i during READY is ignored
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        vectors++;
        if (st !== 5'b11000) begin
            miscompares++;
            $display("FAIL set_start_in_ready: got %b want 11000", st);
        end
        set_req_i = 1'b1;
        tick();
        vectors++;
        if (st !== 5'b10001) begin
            miscompares++;
            $display("FAIL set_pulse: got %b want 10001", st);
        end
        tick();
        vectors++;
        if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL set_second_req: got %b want 00000", st);
        end
        set_req_i = 1'b0;
    endtask

    task automatic test_idle_ignores();
        set_req_i      = 1'b1;
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = {8{8'h77}};
        tick();
        vectors++;
        if (st !== 5'b00000 || a0 !== 8'h04) begin
            miscompares++;
            $display("FAIL idle_ignore: status %b a_0 %h, want 00000 a_0 04", st, a0);
        end
        // start and set together in IDLE: start wins
        s_if.s_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i   = 1'b0;
        set_req_i = 1'b0;
        vectors++;
        if (st !== 5'b10100) begin
            miscompares++;
            $display("FAIL idle_start_wins: got %b want 10100", st);
        end
    endtask

    task automatic test_gap();
        int pulses;
        pulses = 0;
        for (int w = 1; w <= D; w++) begin
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = {8{8'(w)}};
            tick();
            pulses += int'(prep);
            vectors++;
            if (a0 !== 8'(w) || prep !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_word%0d: prep %b a_0 %h, want 1 a_0 %h", w, prep, a0, 8'(w));
            end
            if (w == 2) begin
                s_if.s_valid_i = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    pulses += int'(prep);
                    vectors++;
                    if (st !== 5'b10100 || a0 !== 8'h02) begin
                        miscompares++;
                        $display("FAIL gap_hold%0d: status %b a_0 %h, want 10100 a_0 02", g, st, a0);
                    end
                end
            end
        end
        vectors++;
        if (st !== 5'b11010) begin
            miscompares++;
            $display("FAIL gap_loaded: got %b want 11010", st);
        end
        // extra word after the last one is not accepted
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = {8{8'h05}};
        tick();
        pulses += int'(prep);
        s_if.s_valid_i = 1'b0;
        vectors++;
        if (st !== 5'b11000 || a0 !== 8'h04) begin
            miscompares++;
            $display("FAIL gap_extra: status %b a_0 %h, want 11000 a_0 04", st, a0);
        end
        vectors++;
        if (pulses !== D) begin
            miscompares++;
            $display("FAIL gap_pulses: got %0d want %0d", pulses, D);
        end
        set_req_i = 1'b1;
        tick();
        set_req_i = 1'b0;
        tick();
        vectors++;
        if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL gap_return_idle: got %b want 00000", st);
        end
    endtask

    task automatic test_reset_midload();
        logic [8*WW-1:0] word;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int w = 1; w <= 2; w++) begin
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = {8{8'(w)}};
            tick();
        end
        s_if.s_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (st !== 5'b00000 || lanes !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_midload: status %b data %h, want 00000 data 0", st, lanes);
        end
        tick();
        rst = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int w = 1; w <= D; w++) begin
            word = 64'h1122334455667788 + 64'(w);
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = word;
            tick();
            vectors++;
            if (lanes !== word) begin
                miscompares++;
                $display("FAIL reload_word%0d: lanes %h want %h", w, lanes, word);
            end
        end
        s_if.s_valid_i = 1'b0;
        vectors++;
        if (st !== 5'b11010 || a0 !== 8'h11 || d1 !== 8'h8C) begin
            miscompares++;
            $display("FAIL reload_done: status %b a_0 %h d_1 %h, want 11010 11 8c", st, a0, d1);
        end
        set_req_i = 1'b1;
        tick();
        set_req_i = 1'b0;
        tick();
    endtask

`ifdef WEIGHT_LOAD_ABORT_EN
    task automatic test_abort();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = {8{8'(w)}};
            abort_i        = (w == 3);
            tick();
        end
        s_if.s_valid_i = 1'b0;
        abort_i        = 1'b0;
        vectors++;
        if (st !== 5'b00010 || a0 !== 8'h03) begin
            miscompares++;
            $display("FAIL abort_with_hs: status %b a_0 %h, want 00010 a_0 03", st, a0);
        end
        set_req_i = 1'b1;
        tick();
        set_req_i = 1'b0;
        vectors++;
        if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_idle: got %b want 00000", st);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int w = 1; w <= D; w++) begin
            s_if.s_valid_i = 1'b1;
            s_if.s_data_i  = {8{8'(w + 8)}};
            tick();
        end
        s_if.s_valid_i = 1'b0;
        vectors++;
        if (st !== 5'b11010 || a0 !== 8'h0C) begin
            miscompares++;
            $display("FAIL abort_reload: status %b a_0 %h, want 11010 a_0 0c", st, a0);
        end
        // abort beats set_req in READY
        abort_i   = 1'b1;
        set_req_i = 1'b1;
        tick();
        abort_i   = 1'b0;
        set_req_i = 1'b0;
        vectors++;
        if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_over_set: got %b want 00000", st);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_set();
        test_idle_ignores();
        test_gap();
        test_reset_midload();
`ifdef WEIGHT_LOAD_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
